sensor_conditioner: RTL and testbench

Front-end stage between the raw lot sensors (entry loop, exit loop, payment terminal) and the parking controller top level. It synchronises each raw input, debounces it, and issues exactly one single-cycle pulse per debounced rising edge. These pulses drive the controller's entry_pulse, exit_pulse_for_system and payment_received inputs. It also latches the exit slot selection with each exit pulse, arbitrates coincident events, and counts rejected glitches.

---
 rtl/sensor_conditioner_pkg.sv | 18 +
 rtl/sensor_conditioner_if.sv | 32 +++
 rtl/sensor_conditioner_debounce_oneshot.sv | 84 ++++++++
 rtl/sensor_conditioner.sv | 89 ++++++++
 tb/tb_sensor_conditioner.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_conditioner_pkg.sv
// Shared types and constants for the lot-sensor conditioning front end.
package sensor_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RISE_CHK = 2'd1,
    ACTIVE   = 2'd2,
    FALL_CHK = 2'd3
  } chan_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int SLOT_W                  = 2;

  function automatic logic [1:0] count_ones3(input logic a, input logic b, input logic c);
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

endpackage

// File: rtl/sensor_conditioner_if.sv
// Raw sensor inputs and conditioned outputs between the lot sensors and the controller.
interface sensor_conditioner_if #(
  parameter int GLITCH_W = 8
);
  import sensor_conditioner_pkg::*;

  logic              entry_sensor_raw;
  logic              exit_sensor_raw;
  logic              payment_raw;
  logic [SLOT_W-1:0] exit_car_select_raw;

  logic                entry_pulse;
  logic                exit_pulse;
  logic                payment_pulse;
  logic [SLOT_W-1:0]   exit_car_select;
  logic                entry_present;
  logic                exit_present;
  logic [GLITCH_W-1:0] glitch_count;

  modport master (
    output entry_sensor_raw, exit_sensor_raw, payment_raw, exit_car_select_raw,
    input  entry_pulse, exit_pulse, payment_pulse, exit_car_select,
           entry_present, exit_present, glitch_count
  );

  modport slave (
    input  entry_sensor_raw, exit_sensor_raw, payment_raw, exit_car_select_raw,
    output entry_pulse, exit_pulse, payment_pulse, exit_car_select,
           entry_present, exit_present, glitch_count
  );

endinterface

// File: rtl/sensor_conditioner_debounce_oneshot.sv
// One sensor channel: 2-flop synchroniser, debounce FSM, single-cycle pulse and glitch strobe.
module debounce_oneshot
  import sensor_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic qualify_o,
  output logic pulse_o,
  output logic present_o,
  output logic glitch_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, glitch_q;
  logic             qualify, glitch_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pulse_q  <= qualify;
      glitch_q <= glitch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = RISE_CHK;
          cnt_d   = CNT_W'(1);
        end
      end
      RISE_CHK: begin
        if (!sync2_q)              state_d = IDLE;
        else if (cnt_q == LAST_CNT) state_d = ACTIVE;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      ACTIVE: begin
        if (!sync2_q) begin
          state_d = FALL_CHK;
          cnt_d   = CNT_W'(1);
        end
      end
      FALL_CHK: begin
        if (sync2_q)                state_d = ACTIVE;
        else if (cnt_q == LAST_CNT) state_d = IDLE;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // A bounce back inside either check window is a rejected transition.
  always_comb begin
    qualify   = (state_q == RISE_CHK) && sync2_q && (cnt_q == LAST_CNT);
    glitch_d  = ((state_q == RISE_CHK) && !sync2_q) || ((state_q == FALL_CHK) && sync2_q);
    present_o = (state_q == ACTIVE) || (state_q == FALL_CHK);
  end

  assign qualify_o = qualify;
  assign pulse_o   = pulse_q;
  assign glitch_o  = glitch_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions entry/exit/payment sensors into single-cycle pulses; defers exit by one cycle
// when it coincides with entry and keeps a saturating glitch count.
module sensor_conditioner
  import sensor_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 4,
  parameter int GLITCH_W        = 8
) (
  input logic                 clk,
  input logic                 rst,
  sensor_conditioner_if.slave bus
);

  localparam logic [GLITCH_W:0] GLITCH_MAX = {1'b0, {GLITCH_W{1'b1}}};

  logic entry_qualify, entry_pulse, entry_present, entry_glitch;
  logic exit_qualify, exit_pulse, exit_present, exit_glitch;
  logic pay_qualify_unused, pay_pulse, pay_present_unused, pay_glitch;

  logic [SLOT_W-1:0]   sel_sync1_q, sel_sync2_q;
  logic [SLOT_W-1:0]   sel_q, sel_d, pend_sel_q, pend_sel_d;
  logic                exit_pending_q, exit_pending_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic [GLITCH_W:0]   glitch_sum;

  debounce_oneshot #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_entry (
    .clk(clk), .rst(rst), .raw_i(bus.entry_sensor_raw),
    .qualify_o(entry_qualify), .pulse_o(entry_pulse),
    .present_o(entry_present), .glitch_o(entry_glitch)
  );

  debounce_oneshot #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_exit (
    .clk(clk), .rst(rst), .raw_i(bus.exit_sensor_raw),
    .qualify_o(exit_qualify), .pulse_o(exit_pulse),
    .present_o(exit_present), .glitch_o(exit_glitch)
  );

  debounce_oneshot #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_payment (
    .clk(clk), .rst(rst), .raw_i(bus.payment_raw),
    .qualify_o(pay_qualify_unused), .pulse_o(pay_pulse),
    .present_o(pay_present_unused), .glitch_o(pay_glitch)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_sync1_q    <= '0;
      sel_sync2_q    <= '0;
      sel_q          <= '0;
      pend_sel_q     <= '0;
      exit_pending_q <= 1'b0;
      glitch_q       <= '0;
    end else begin
      sel_sync1_q    <= bus.exit_car_select_raw;
      sel_sync2_q    <= sel_sync1_q;
      sel_q          <= sel_d;
      pend_sel_q     <= pend_sel_d;
      exit_pending_q <= exit_pending_d;
      glitch_q       <= glitch_d;
    end
  end

  // The select is captured when exit qualifies; a deferred exit parks it until emission.
  always_comb begin
    exit_pending_d = exit_pulse && entry_pulse;
    sel_d          = sel_q;
    pend_sel_d     = pend_sel_q;
    if (exit_qualify) begin
      if (entry_qualify) pend_sel_d = sel_sync2_q;
      else               sel_d      = sel_sync2_q;
    end
    if (exit_pending_d) sel_d = pend_sel_q;
  end

  always_comb begin
    glitch_sum = {1'b0, glitch_q}
               + (GLITCH_W + 1)'(count_ones3(entry_glitch, exit_glitch, pay_glitch));
    glitch_d   = (glitch_sum > GLITCH_MAX) ? GLITCH_MAX[GLITCH_W-1:0] : glitch_sum[GLITCH_W-1:0];
  end

  assign bus.entry_pulse     = entry_pulse;
  assign bus.exit_pulse      = (exit_pulse && !entry_pulse) || exit_pending_q;
  assign bus.payment_pulse   = pay_pulse;
  assign bus.exit_car_select = sel_q;
  assign bus.entry_present   = entry_present;
  assign bus.exit_present    = exit_present;
  assign bus.glitch_count    = glitch_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: expected pulses are queued with their cycle and select.
module tb_sensor_conditioner;
  import sensor_conditioner_pkg::*;

  typedef struct {
    int         cyc;
    logic [1:0] sel;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   expGlitch;

  exp_t entryQ[$];
  exp_t exitQ[$];
  exp_t payQ[$];
  exp_t e;

  sensor_conditioner_if #(.GLITCH_W(8)) bus();

  sensor_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(4), .GLITCH_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pop the scoreboard whenever the DUT emits a pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.entry_pulse || bus.exit_pulse || bus.payment_pulse) begin
        checks++;
        if (bus.entry_pulse && bus.exit_pulse) begin
          errors++;
          $display("[TB] FAIL pulse_overlap: entry and exit both high at cycle %0d, required never", cyc);
        end
      end
      if (bus.entry_pulse) begin
        checks++;
        if (entryQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL entry_unexpected: entry_pulse at cycle %0d, none expected", cyc);
        end else begin
          e = entryQ.pop_front();
          if (cyc !== e.cyc) begin
            errors++;
            $display("[TB] FAIL entry_cycle: got cycle %0d, expected %0d", cyc, e.cyc);
          end
        end
      end
      if (bus.exit_pulse) begin
        checks++;
        if (exitQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL exit_unexpected: exit_pulse at cycle %0d, none expected", cyc);
        end else begin
          e = exitQ.pop_front();
          if (cyc !== e.cyc || bus.exit_car_select !== e.sel) begin
            errors++;
            $display("[TB] FAIL exit_event: got cycle %0d sel %0d, expected cycle %0d sel %0d",
                     cyc, bus.exit_car_select, e.cyc, e.sel);
          end
        end
      end
      if (bus.payment_pulse) begin
        checks++;
        if (payQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL payment_unexpected: payment_pulse at cycle %0d, none expected", cyc);
        end else begin
          e = payQ.pop_front();
          if (cyc !== e.cyc) begin
            errors++;
            $display("[TB] FAIL payment_cycle: got cycle %0d, expected %0d", cyc, e.cyc);
          end
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.entry_sensor_raw    = 1'b0;
    bus.exit_sensor_raw     = 1'b0;
    bus.payment_raw         = 1'b0;
    bus.exit_car_select_raw = 2'd0;
    waitCycles(3);
    checks++;
    if ({bus.entry_pulse, bus.exit_pulse, bus.payment_pulse} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_pulses: got %b, expected 000",
               {bus.entry_pulse, bus.exit_pulse, bus.payment_pulse});
    end
    checks++;
    if ({bus.entry_present, bus.exit_present, bus.exit_car_select} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_state: got %b, expected 0000",
               {bus.entry_present, bus.exit_present, bus.exit_car_select});
    end
    checks++;
    if (bus.glitch_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_glitch: got %0d, expected 0", bus.glitch_count);
    end
    rst = 1'b0;
    expGlitch = 0;
    waitCycles(2);
  endtask

  task automatic test_entry();
    int k, m;
    k = cyc;
    bus.entry_sensor_raw = 1'b1;
    entryQ.push_back('{cyc: k + 6, sel: 2'd0});
    waitCycles(5);
    checks++;
    if (bus.entry_present !== 1'b0) begin
      errors++;
      $display("[TB] FAIL entry_present_early: got %b, expected 0", bus.entry_present);
    end
    waitCycles(1);
    checks++;
    if (bus.entry_present !== 1'b1) begin
      errors++;
      $display("[TB] FAIL entry_present_rise: got %b, expected 1", bus.entry_present);
    end
    waitCycles(24);
    m = cyc;
    bus.entry_sensor_raw = 1'b0;
    waitCycles(5);
    checks++;
    if (bus.entry_present !== 1'b1) begin
      errors++;
      $display("[TB] FAIL entry_present_hold: got %b, expected 1 at cycle %0d", bus.entry_present, m + 5);
    end
    waitCycles(1);
    checks++;
    if (bus.entry_present !== 1'b0) begin
      errors++;
      $display("[TB] FAIL entry_present_fall: got %b, expected 0", bus.entry_present);
    end
    waitCycles(5);
    checks++;
    if (entryQ.size() + exitQ.size() + payQ.size() != 0 || bus.glitch_count !== 8'(expGlitch)) begin
      errors++;
      $display("[TB] FAIL entry_drain: pending %0d glitch %0d, expected pending 0 glitch %0d",
               entryQ.size() + exitQ.size() + payQ.size(), bus.glitch_count, expGlitch);
    end
  endtask

  task automatic test_glitch();
    bus.entry_sensor_raw = 1'b1;
    waitCycles(2);
    bus.entry_sensor_raw = 1'b0;
    waitCycles(8);
    expGlitch++;
    checks++;
    if (bus.glitch_count !== 8'(expGlitch) || bus.entry_present !== 1'b0) begin
      errors++;
      $display("[TB] FAIL short_glitch: glitch %0d present %b, expected glitch %0d present 0",
               bus.glitch_count, bus.entry_present, expGlitch);
    end
  endtask

  task automatic test_exit_select();
    int k;
    k = cyc;
    bus.exit_car_select_raw = 2'd3;
    bus.exit_sensor_raw     = 1'b1;
    exitQ.push_back('{cyc: k + 6, sel: 2'd3});
    waitCycles(10);
    bus.exit_car_select_raw = 2'd1;
    waitCycles(10);
    checks++;
    if (bus.exit_car_select !== 2'd3 || bus.exit_present !== 1'b1) begin
      errors++;
      $display("[TB] FAIL exit_select_hold: sel %0d present %b, expected sel 3 present 1",
               bus.exit_car_select, bus.exit_present);
    end
    bus.exit_sensor_raw = 1'b0;
    waitCycles(8);
    checks++;
    if (exitQ.size() != 0 || bus.exit_present !== 1'b0) begin
      errors++;
      $display("[TB] FAIL exit_drain: pending %0d present %b, expected 0 and 0",
               exitQ.size(), bus.exit_present);
    end
  endtask

  task automatic test_coincident();
    int k;
    k = cyc;
    bus.exit_car_select_raw = 2'd2;
    bus.entry_sensor_raw    = 1'b1;
    bus.exit_sensor_raw     = 1'b1;
    entryQ.push_back('{cyc: k + 6, sel: 2'd0});
    exitQ.push_back('{cyc: k + 7, sel: 2'd2});
    waitCycles(6);
    bus.exit_car_select_raw = 2'd0;
    waitCycles(4);
    checks++;
    if (bus.exit_car_select !== 2'd2) begin
      errors++;
      $display("[TB] FAIL deferred_select: got %0d, expected 2", bus.exit_car_select);
    end
    bus.entry_sensor_raw = 1'b0;
    bus.exit_sensor_raw  = 1'b0;
    waitCycles(8);
    checks++;
    if (entryQ.size() + exitQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL coincident_drain: got %0d pending, expected 0", entryQ.size() + exitQ.size());
    end
  endtask

  task automatic test_bounce();
    int k;
    k = cyc;
    bus.exit_car_select_raw = 2'd1;
    bus.exit_sensor_raw     = 1'b1;
    exitQ.push_back('{cyc: k + 6, sel: 2'd1});
    waitCycles(12);
    bus.exit_sensor_raw = 1'b0;
    waitCycles(1);
    bus.exit_sensor_raw = 1'b1;
    waitCycles(10);
    expGlitch++;
    checks++;
    if (bus.glitch_count !== 8'(expGlitch) || bus.exit_present !== 1'b1 || bus.exit_car_select !== 2'd1) begin
      errors++;
      $display("[TB] FAIL bounce: glitch %0d present %b sel %0d, expected glitch %0d present 1 sel 1",
               bus.glitch_count, bus.exit_present, bus.exit_car_select, expGlitch);
    end
    bus.exit_sensor_raw = 1'b0;
    waitCycles(8);
    checks++;
    if (exitQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL bounce_drain: got %0d pending, expected 0", exitQ.size());
    end
  endtask

  task automatic test_back_to_back();
    int k;
    k = cyc;
    bus.entry_sensor_raw = 1'b1;
    bus.payment_raw      = 1'b1;
    entryQ.push_back('{cyc: k + 6, sel: 2'd0});
    payQ.push_back('{cyc: k + 6, sel: 2'd0});
    waitCycles(10);
    bus.entry_sensor_raw = 1'b0;
    bus.payment_raw      = 1'b0;
    waitCycles(8);
    checks++;
    if (entryQ.size() + payQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL entry_payment_drain: got %0d pending, expected 0", entryQ.size() + payQ.size());
    end
  endtask

  task automatic test_reset_mid();
    int r;
    bus.payment_raw = 1'b1;
    waitCycles(3);
    rst = 1'b1;
    waitCycles(2);
    checks++;
    if (bus.payment_pulse !== 1'b0 || bus.glitch_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_state: pulse %b glitch %0d, expected 0 and 0",
               bus.payment_pulse, bus.glitch_count);
    end
    rst = 1'b0;
    r = cyc;
    expGlitch = 0;
    payQ.push_back('{cyc: r + 6, sel: 2'd0});
    waitCycles(10);
    bus.payment_raw = 1'b0;
    waitCycles(8);
    checks++;
    if (payQ.size() != 0 || bus.glitch_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_drain: pending %0d glitch %0d, expected 0 and 0",
               payQ.size(), bus.glitch_count);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 86; i++) begin
      bus.entry_sensor_raw = 1'b1;
      bus.exit_sensor_raw  = 1'b1;
      bus.payment_raw      = 1'b1;
      waitCycles(2);
      bus.entry_sensor_raw = 1'b0;
      bus.exit_sensor_raw  = 1'b0;
      bus.payment_raw      = 1'b0;
      waitCycles(6);
      expGlitch = (expGlitch + 3 > 255) ? 255 : expGlitch + 3;
      if (i == 83 || i == 84 || i == 85) begin
        checks++;
        if (bus.glitch_count !== 8'(expGlitch)) begin
          errors++;
          $display("[TB] FAIL glitch_saturate: iteration %0d got %0d, expected %0d",
                   i, bus.glitch_count, expGlitch);
        end
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    expGlitch = 0;
    test_reset();
    test_entry();
    test_glitch();
    test_exit_select();
    test_coincident();
    test_bounce();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
